rat_reduce: RTL and testbench
=============================

RAT_REDUCE -- requirements
Module: rat_reduce

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the bit width of numerator, denominator and quotients.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  in_num/in_den hold a fraction to reduce.
REQ-005 SHALL have port in_ready  output  1  block accepts a fraction this cycle.
REQ-006 SHALL have port in_num  input  WIDTH  numerator, two's complement (the add_sub s_num output).
REQ-007 SHALL have port in_den  input  WIDTH  denominator, unsigned (the add_sub s_den output).
REQ-008 SHALL have port out_valid  output  1  out_num/out_den/out_err hold a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out_num  output  WIDTH  reduced numerator, two's complement.
REQ-011 SHALL have port out_den  output  WIDTH  reduced denominator, unsigned.
REQ-012 SHALL have port out_err  output  1  input denominator was zero.

Function
REQ-013 SHALL run an FSM with states IDLE, GCD, DIV, DONE.
REQ-014 In IDLE, SHALL drive in_ready=1; in all other states, SHALL drive in_ready=0.
REQ-015 On in_valid and in_ready, SHALL capture sign=in_num[WIDTH-1], mag=|in_num| (WIDTH-bit unsigned, so -2^(WIDTH-1) gives 2^(WIDTH-1)) and den=in_den.
REQ-016 On a capture with in_den==0, SHALL go to DONE with out_num=in_num, out_den=0, out_err=1.
REQ-017 On a capture with in_den!=0, SHALL go to GCD with out_err=0 for that result.
REQ-018 GCD SHALL compute g=gcd(mag,den) by binary Stein, one step per cycle:
- strip common factors of two and count them in k;
- then each cycle, either halve an even operand, or replace the larger odd operand with the difference;
- exit when one operand is zero, with g = (other operand) << k.
REQ-019 GCD with mag==0 SHALL give g=den.
REQ-020 DIV SHALL compute qn=mag/g and qd=den/g with two parallel restoring dividers in exactly WIDTH cycles, then go to DONE.
REQ-021 In DONE, SHALL drive out_num = sign ? -qn : qn (two's complement), out_den=qd and out_valid=1.
REQ-022 A zero numerator SHALL produce 0/1 via the normal path.
REQ-023 SHALL hold out_valid and all outputs stable until out_ready=1, then return to IDLE the next cycle with out_valid=0.
REQ-024 Total latency from capture to out_valid SHALL be at most 4*WIDTH+4 cycles; a zero-denominator result SHALL appear exactly 1 cycle after capture.
REQ-025 SHALL take no new capture while a result is pending (in_ready=0 until return to IDLE); back-to-back throughput is one fraction per latency+1 cycles.
REQ-026 out_den SHALL never be zero when out_err=0.

Reset
REQ-027 With rst=1 at a clock edge, SHALL enter IDLE with out_valid=0, out_num=0, out_den=0, out_err=0 (and out_gcd=0 when present); in_ready=1 from the first cycle after rst deasserts.
REQ-028 rst in any state, including mid-GCD, mid-DIV or during a DONE stall, SHALL abort the operation and discard the operand with no output produced.

Configuration
REQ-029 SHALL support macro RAT_REDUCE_GCD_PORT_EN.
- Defined: adds port out_gcd  output  WIDTH, equal to g, valid with out_valid; on out_err=1 it reads 0.
- Undefined: port absent; all other behaviour identical.

Verification
REQ-030 Bench SHALL cover: in_num=6, in_den=8 -> out_num=3, out_den=4, out_err=0 (out_gcd=2 if enabled).
REQ-031 Bench SHALL cover: in_num=32'hFFFFFFF6 (-10), in_den=4 -> out_num=32'hFFFFFFFB (-5), out_den=2.
REQ-032 Bench SHALL cover: in_num=0, in_den=7 -> 0/1; in_num=7, in_den=13 -> 7/13; all within 4*WIDTH+4 cycles.
REQ-033 Bench SHALL cover: in_num=5, in_den=0 -> out_num=5, out_den=0, out_err=1 exactly 1 cycle after capture.
REQ-034 Bench SHALL cover: in_num=32'h80000000, in_den=2 -> out_num=32'hC0000000, out_den=1.
REQ-035 Bench SHALL cover: out_ready held low 10 cycles -> outputs stable throughout; rst pulsed mid-DIV -> out_valid stays 0 and in_ready=1 the next cycle; 1000 random add_sub-range operands checked against a software GCD model.

Source files
------------

// File: rtl/rat_reduce.sv
// Reduces a signed fraction num/den to lowest terms: binary-GCD, then two parallel restoring dividers.
// Optional macro RAT_REDUCE_GCD_PORT_EN adds the out_gcd result port.
module rat_reduce #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_num,
    output logic [WIDTH-1:0] out_den,
    output logic             out_err,
`ifdef RAT_REDUCE_GCD_PORT_EN
    output logic [WIDTH-1:0] out_gcd,
`endif
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // out_valid and the result stay put until out_ready, and in_ready is 1 only in IDLE.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GCD  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    k_q, k_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] rn_q, rn_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_num_q, out_num_d;
    logic [WIDTH-1:0] out_den_q, out_den_d;
    logic             out_err_q, out_err_d;
    logic [WIDTH-1:0] gcd_out_q, gcd_out_d;

    logic [WIDTH-1:0] mag_in;
    logic [WIDTH:0]   trial_n, trial_d;
    logic             ge_n, ge_d;
    logic [WIDTH-1:0] rn_next, rd_next;
    logic [WIDTH-1:0] qn_next, qd_next;

    assign mag_in  = in_num[WIDTH-1] ? (~in_num + 1'b1) : in_num;

    // During DIV, a_q/b_q are the quotient shift registers holding the unconsumed dividend bits.
    assign trial_n = {rn_q, a_q[WIDTH-1]};
    assign trial_d = {rd_q, b_q[WIDTH-1]};
    assign ge_n    = (trial_n >= {1'b0, g_q});
    assign ge_d    = (trial_d >= {1'b0, g_q});
    assign rn_next = ge_n ? WIDTH'(trial_n - {1'b0, g_q}) : trial_n[WIDTH-1:0];
    assign rd_next = ge_d ? WIDTH'(trial_d - {1'b0, g_q}) : trial_d[WIDTH-1:0];
    assign qn_next = {a_q[WIDTH-2:0], ge_n};
    assign qd_next = {b_q[WIDTH-2:0], ge_d};

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        den_d       = den_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        cnt_d       = cnt_q;
        g_d         = g_q;
        rn_d        = rn_q;
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_num_d   = out_num_q;
        out_den_d   = out_den_q;
        out_err_d   = out_err_q;
        gcd_out_d   = gcd_out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = in_num[WIDTH-1];
                    mag_d  = mag_in;
                    den_d  = in_den;
                    a_d    = mag_in;
                    b_d    = in_den;
                    k_d    = '0;
                    if (in_den == '0) begin
                        out_num_d   = in_num;
                        out_den_d   = '0;
                        out_err_d   = 1'b1;
                        gcd_out_d   = '0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        out_err_d = 1'b0;
                        state_d   = GCD;
                    end
                end
            end
            GCD: begin
                if (a_q == '0 || b_q == '0) begin
                    g_d     = (a_q == '0 ? b_q : a_q) << k_q;
                    a_d     = mag_q;
                    b_d     = den_q;
                    rn_d    = '0;
                    rd_d    = '0;
                    cnt_d   = '0;
                    state_d = DIV;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 1'b1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // Difference of two odds is even, so its halving is folded into the same cycle.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
            end
            DIV: begin
                a_d   = qn_next;
                b_d   = qd_next;
                rn_d  = rn_next;
                rd_d  = rd_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_num_d   = sign_q ? (~qn_next + 1'b1) : qn_next;
                    out_den_d   = qd_next;
                    gcd_out_d   = g_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            den_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            g_q         <= '0;
            rn_q        <= '0;
            rd_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_num_q   <= '0;
            out_den_q   <= '0;
            out_err_q   <= 1'b0;
            gcd_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            den_q       <= den_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            cnt_q       <= cnt_d;
            g_q         <= g_d;
            rn_q        <= rn_d;
            rd_q        <= rd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_num_q   <= out_num_d;
            out_den_q   <= out_den_d;
            out_err_q   <= out_err_d;
            gcd_out_q   <= gcd_out_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_num   = out_num_q;
    assign out_den   = out_den_q;
    assign out_err   = out_err_q;
    assign dbg_state = state_q;
`ifdef RAT_REDUCE_GCD_PORT_EN
    assign out_gcd   = gcd_out_q;
`else
    logic unused_gcd;
    assign unused_gcd = ^gcd_out_q;
`endif

endmodule

// File: tb/tb_rat_reduce.sv
// Self-checking bench for rat_reduce: directed fractions, reset aborts, output stall, and
// random operands against a Euclid-based reference model.
module tb_rat_reduce;
    localparam int WIDTH   = 32;
    localparam int LAT_MAX = 4 * WIDTH + 4;
    localparam int EW      = 3 * WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_num;
    logic [WIDTH-1:0] out_den;
    logic             out_err;
    logic [1:0]       dbg_state;
    logic [WIDTH-1:0] gcd_obs;

    int n_checks = 0;
    int n_fails  = 0;
    // Expected record layout: {err, gcd, den, num}
    logic [EW-1:0] exp_q[$];

    always #5 clk = ~clk;

`ifdef RAT_REDUCE_GCD_PORT_EN
    logic [WIDTH-1:0] out_gcd;
    assign gcd_obs = out_gcd;
`else
    assign gcd_obs = '0;
`endif

    rat_reduce #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_den    (in_den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_den   (out_den),
        .out_err   (out_err),
`ifdef RAT_REDUCE_GCD_PORT_EN
        .out_gcd   (out_gcd),
`endif
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] model(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den);
        longint            s;
        longint unsigned   mag, a, b, t, qn, qd;
        logic [WIDTH-1:0]  num_e;
        if (den == '0) return {1'b1, {WIDTH{1'b0}}, {WIDTH{1'b0}}, num};
        s   = longint'($signed(num));
        mag = (s < 0) ? longint'(-s) : longint'(s);
        a   = mag;
        b   = {32'd0, den};
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        qn    = mag / a;
        qd    = {32'd0, den} / a;
        num_e = (s < 0) ? WIDTH'(64'd0 - qn) : WIDTH'(qn);
        return {1'b0, WIDTH'(a), WIDTH'(qd), num_e};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_one(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den,
                           input logic [EW-1:0] exp, input int hold);
        int            waited;
        int            lat;
        logic [EW-1:0] e;
        logic [EW-1:0] snap;
        bit            stable;
        waited = 0;
        while (!in_ready && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_num   = num;
        in_den   = den;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(exp);
        check("in_ready_busy", in_ready, 0);
        lat = 1;
        while (!out_valid && lat < LAT_MAX) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid", out_valid, 1);
        check("latency_bound", (lat <= LAT_MAX), 1);
        if (den == '0) check("zero_den_latency", lat, 1);
        snap   = {out_err, gcd_obs, out_den, out_num};
        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if ({out_err, gcd_obs, out_den, out_num} !== snap || !out_valid || in_ready) stable = 1'b0;
        end
        if (hold > 0) check("stall_stable", stable, 1);
        e = exp_q.pop_front();
        check("out_num", out_num, e[WIDTH-1:0]);
        check("out_den", out_den, e[2*WIDTH-1:WIDTH]);
        check("out_err", out_err, e[EW-1]);
`ifdef RAT_REDUCE_GCD_PORT_EN
        check("out_gcd", out_gcd, e[3*WIDTH-1:2*WIDTH]);
`endif
        if (!out_err) check("den_nonzero", (out_den != '0), 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", out_valid, 0);
        check("release_ready", in_ready, 1);
    endtask

    task automatic abort_in(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den,
                            input logic [1:0] target, input int delay);
        int waited;
        bit quiet;
        in_valid = 1'b1;
        in_num   = num;
        in_den   = den;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited   = 0;
        while (dbg_state != target && waited < LAT_MAX) begin
            @(posedge clk); #1;
            waited++;
        end
        check("reach_state", dbg_state, target);
        repeat (delay) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        check("abort_num", out_num, 0);
        quiet = 1'b1;
        repeat (LAT_MAX) begin
            @(posedge clk); #1;
            if (out_valid) quiet = 1'b0;
        end
        check("abort_no_output", quiet, 1);
    endtask

    typedef struct {
        logic [WIDTH-1:0] num;
        logic [WIDTH-1:0] den;
        logic [WIDTH-1:0] enum_v;
        logic [WIDTH-1:0] eden;
        logic             err;
        logic [WIDTH-1:0] g;
    } vec_t;

    initial begin
        vec_t             dir[6];
        logic [WIDTH-1:0] num;
        logic [WIDTH-1:0] den;
        logic [WIDTH-1:0] f;
        int               r;

        dir[0] = '{32'd6,          32'd8,  32'd3,          32'd4,  1'b0, 32'd2};
        dir[1] = '{32'hFFFFFFF6,   32'd4,  32'hFFFFFFFB,   32'd2,  1'b0, 32'd2};
        dir[2] = '{32'd0,          32'd7,  32'd0,          32'd1,  1'b0, 32'd7};
        dir[3] = '{32'd7,          32'd13, 32'd7,          32'd13, 1'b0, 32'd1};
        dir[4] = '{32'd5,          32'd0,  32'd5,          32'd0,  1'b1, 32'd0};
        dir[5] = '{32'h80000000,   32'd2,  32'hC0000000,   32'd1,  1'b0, 32'd2};

        in_valid  = 1'b0;
        in_num    = '0;
        in_den    = '0;
        out_ready = 1'b0;
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_num", out_num, 0);
        check("rst_out_den", out_den, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef RAT_REDUCE_GCD_PORT_EN
        check("rst_out_gcd", out_gcd, 0);
`endif

        foreach (dir[i])
            run_one(dir[i].num, dir[i].den,
                    {dir[i].err, dir[i].g, dir[i].eden, dir[i].enum_v}, (i == 0) ? 10 : 0);

        abort_in(32'd7, 32'd13, 2'd2, 3);
        abort_in(32'd96, 32'd64, 2'd1, 2);
        abort_in(32'd5, 32'd0, 2'd3, 4);
        run_one(32'd6, 32'd8, {1'b0, 32'd2, 32'd4, 32'd3}, 2);

        for (int n = 0; n < 1000; n++) begin
            r = $urandom_range(0, 15);
            if (r == 0) begin
                num = $urandom;
                den = '0;
            end else if (r < 5) begin
                num = $urandom;
                den = $urandom;
                if (den == '0) den = 32'd1;
            end else begin
                f   = $urandom_range(1, 4096);
                num = f * $urandom_range(0, 50000);
                den = f * $urandom_range(1, 50000);
                if ($urandom_range(0, 1) == 1) num = -num;
            end
            run_one(num, den, model(num, den), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
